// File: rtl/mux41_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux41_pkg
// Description : Shared definitions for the 4-to-1 round-robin collector.
//               Lane count, select width, FSM state type and the helper
//               that locates a lane's data slice in the flattened bus.
// Ports       : none (package)
// Config      : none here; MUX41_STATS_EN is consumed by mux41_rr.
// Revision    : 1.0  initial release
// ============================================================================
package mux41_pkg;

    localparam int LANES = 4;
    localparam int SEL_W = 2;

    // EMPTY: no word held in the output register; FULL: word held.
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Bit offset of a lane's data field inside a flattened LANES*width bus.
    function automatic int lane_slice(input logic [SEL_W-1:0] lane, input int width);
        return int'(lane) * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb4.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb4
// Description : Combinational 4-way round-robin picker. Searches lanes in
//               the order ptr+1, ptr+2, ptr+3, ptr+4 (mod 4) and grants the
//               first requester. No grant when en is low.
// Ports       : req[3:0]     in   per-lane request
//               ptr[1:0]     in   last granted lane
//               en           in   grant enable
//               gnt[3:0]     out  one-hot grant (or zero)
//               gnt_idx[1:0] out  index of granted lane (0 when none)
//               any          out  a grant was issued
// Revision    : 1.0  initial release
// ============================================================================
module rr_arb4
    import mux41_pkg::*;
(
    input  logic [LANES-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             en,
    output logic [LANES-1:0] gnt,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             any
);

    logic [SEL_W-1:0] w_cand;

    // The candidate index relies on 2-bit natural overflow for the wrap 3 -> 0.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        w_cand  = '0;
        for (int i = 1; i <= LANES; i++) begin
            w_cand = ptr + SEL_W'(i);
            if (en && !any && req[w_cand]) begin
                gnt[w_cand] = 1'b1;
                gnt_idx     = w_cand;
                any         = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux41_rr.sv
`default_nettype none
// ============================================================================
// Module      : mux41_rr
// Description : Merges four valid/ready lanes into one registered output
//               stream with round-robin fairness. Each output word carries
//               its 2-bit source lane index on out_sel.
// Ports       : clk                  in   rising-edge clock
//               rst_n                in   synchronous active-low reset
//               in_valid[3:0]        in   per-lane word available
//               in_data[4*W-1:0]     in   lane k data at [k*W +: W]
//               in_ready[3:0]        out  per-lane accept (one-hot or zero)
//               out_valid            out  output word held
//               out_data[W-1:0]      out  output word
//               out_sel[1:0]         out  source lane of out_data
//               out_ready            in   consumer accept
//               grant_cnt[4*CNT_W-1:0] out per-lane accepted-word counters
//                                         (only with MUX41_STATS_EN)
// Config      : MUX41_STATS_EN - adds grant_cnt and saturating counters.
// Revision    : 1.0  initial release
// ============================================================================
module mux41_rr
    import mux41_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [LANES-1:0]     in_valid,
    input  logic [LANES*W-1:0]   in_data,
    output logic [LANES-1:0]     in_ready,
    output logic                 out_valid,
    output logic [W-1:0]         out_data,
    output logic [SEL_W-1:0]     out_sel,
    input  logic                 out_ready
`ifdef MUX41_STATS_EN
    ,
    output logic [LANES*CNT_W-1:0] grant_cnt
`endif
);

    state_t           r_state;
    logic [SEL_W-1:0] r_ptr;
    logic             r_out_valid;
    logic [W-1:0]     r_out_data;
    logic [SEL_W-1:0] r_out_sel;

    logic             w_load;
    logic             w_en;
    logic [LANES-1:0] w_gnt;
    logic [SEL_W-1:0] w_gnt_idx;
    logic             w_any;
    logic [W-1:0]     w_lane_data [LANES];

    // The output register can take a new word when it is empty or is being
    // drained this cycle. Grants are suppressed while reset is asserted.
    assign w_load = (r_state == EMPTY) | out_ready;
    assign w_en   = w_load & rst_n;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign w_lane_data[k] = in_data[lane_slice(SEL_W'(k), W) +: W];
    end

    rr_arb4 u_arb (
        .req     (in_valid),
        .ptr     (r_ptr),
        .en      (w_en),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .any     (w_any)
    );

    // The arbiter only grants requesting lanes, so a grant is an accept.
    assign in_ready = w_gnt;

    // Reset value 3 makes lane 0 the first lane searched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_ptr       <= SEL_W'(LANES - 1);
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else if (w_any) begin
            r_state     <= FULL;
            r_ptr       <= w_gnt_idx;
            r_out_valid <= 1'b1;
            r_out_data  <= w_lane_data[w_gnt_idx];
            r_out_sel   <= w_gnt_idx;
        end else if (w_load) begin
            // Drained (or already empty) with nothing to accept. Data and
            // select are left as they were; only the valid flag drops.
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

`ifdef MUX41_STATS_EN
    logic [CNT_W-1:0] r_cnt [LANES];

    for (genvar k = 0; k < LANES; k++) begin : g_cnt
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_cnt[k] <= '0;
            end else if (w_gnt[k] && (r_cnt[k] != {CNT_W{1'b1}})) begin
                r_cnt[k] <= r_cnt[k] + CNT_W'(1);
            end
        end
        assign grant_cnt[k*CNT_W +: CNT_W] = r_cnt[k];
    end
`else
    // CNT_W only sizes the statistics counters, which are absent here.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux41_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux41_rr
// Description : Self-checking bench for mux41_rr: vector table, hand-written
//               backpressure/reset sequences, randomized traffic against a
//               lane-order reference model, and counter saturation when
//               MUX41_STATS_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mux41_rr;

    localparam int W     = 8;
    localparam int CNT_W = 4;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic [3:0]  in_valid  = '0;
    logic [31:0] in_data   = '0;
    logic        out_ready = 1'b0;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
`ifdef MUX41_STATS_EN
    logic [4*CNT_W-1:0] grant_cnt;
`endif

    mux41_rr #(.W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
`ifdef MUX41_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [3:0] v, input logic [31:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    // Inputs change at posedge+1; combinational checks at posedge+2;
    // registered checks at posedge+1 after the next edge.
    task automatic settle();
        #1;
    endtask

    task automatic clock();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    int         m_ptr  = 3;
    bit         m_held = 1'b0;
    logic [7:0] m_data = '0;
    logic [1:0] m_sel  = '0;

    // Search lanes last+1, last+2, ... (mod 4) for the first requester.
    function automatic int model_pick();
        if (!rst_n) return -1;
        if (m_held && !out_ready) return -1;
        for (int i = 1; i <= 4; i++) begin
            int k;
            k = (m_ptr + i) % 4;
            if (in_valid[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int k);
        logic [3:0] r;
        r = '0;
        if (k >= 0) r[k] = 1'b1;
        return r;
    endfunction

    task automatic model_step(input int k);
        if (!rst_n) begin
            m_held = 1'b0; m_data = '0; m_sel = '0; m_ptr = 3;
        end else if (k >= 0) begin
            m_held = 1'b1;
            m_sel  = 2'(k);
            m_data = in_data[k*8 +: 8];
            m_ptr  = k;
        end else if (!m_held || out_ready) begin
            m_held = 1'b0;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic        ordy;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [1:0]  exp_sel;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int k;

        tbl[0]  = '{4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
        tbl[1]  = '{4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
        tbl[2]  = '{4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2};
        tbl[3]  = '{4'b1111, 32'hA3A2A1A0, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3};
        tbl[4]  = '{4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
        tbl[5]  = '{4'b0100, 32'h005C0000, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h5C};
        tbl[6]  = '{4'b1010, 32'h33001100, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h33};
        tbl[7]  = '{4'b1010, 32'h33001100, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
        tbl[8]  = '{4'b1010, 32'h33001100, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h33};
        tbl[9]  = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00};
        tbl[10] = '{4'b0001, 32'h00000077, 1'b0, 4'b0001, 1'b1, 2'd0, 8'h77};

        // Reset state, with requests present to show no grant during reset.
        rst_n = 1'b0;
        apply(4'b1111, 32'hA3A2A1A0, 1'b1);
        clock();
        settle();
        chk("reset_in_ready", 32'(in_ready), 32'h0);
        clock();
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_out_sel", 32'(out_sel), 32'h0);
        chk("reset_out_data", 32'(out_data), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            apply(tbl[i].valid, tbl[i].data, tbl[i].ordy);
            settle();
            chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].exp_rdy));
            clock();
            chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
            if (tbl[i].exp_ov) begin
                chk($sformatf("tbl%0d_out_sel", i), 32'(out_sel), 32'(tbl[i].exp_sel));
                chk($sformatf("tbl%0d_out_data", i), 32'(out_data), 32'(tbl[i].exp_data));
            end
        end

        // Backpressure: FULL holding lane 0 word 77, last grant lane 0.
        apply(4'b1111, 32'h44332211, 1'b0);
        for (int c = 0; c < 5; c++) begin
            settle();
            chk("bp_in_ready", 32'(in_ready), 32'h0);
            clock();
            chk("bp_out_valid", 32'(out_valid), 32'h1);
            chk("bp_out_sel", 32'(out_sel), 32'h0);
            chk("bp_out_data", 32'(out_data), 32'h77);
        end
        out_ready = 1'b1;
        settle();
        chk("bp_release_in_ready", 32'(in_ready), 32'b0010);
        clock();
        chk("bp_release_sel", 32'(out_sel), 32'h1);
        chk("bp_release_data", 32'(out_data), 32'h22);

        // Reset while FULL discards the held word; lane 0 wins afterwards.
        rst_n = 1'b0;
        settle();
        chk("midrst_in_ready", 32'(in_ready), 32'h0);
        clock();
        chk("midrst_out_valid", 32'(out_valid), 32'h0);
        chk("midrst_out_sel", 32'(out_sel), 32'h0);
        rst_n = 1'b1;
        settle();
        chk("postrst_in_ready", 32'(in_ready), 32'b0001);
        clock();
        chk("postrst_sel", 32'(out_sel), 32'h0);
        chk("postrst_data", 32'(out_data), 32'h11);

        // Randomized traffic against the reference model.
        rst_n = 1'b0;
        apply(4'b0000, 32'h0, 1'b0);
        settle();
        k = model_pick();
        clock();
        model_step(k);
        for (int c = 0; c < 400; c++) begin
            rst_n     = ($urandom_range(0, 49) != 0);
            in_valid  = 4'($urandom) & 4'($urandom | $urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            settle();
            k = model_pick();
            chk("rnd_in_ready", 32'(in_ready), 32'(onehot(k)));
            clock();
            model_step(k);
            chk("rnd_out_valid", 32'(out_valid), 32'(m_held));
            if (m_held) begin
                chk("rnd_out_sel", 32'(out_sel), 32'(m_sel));
                chk("rnd_out_data", 32'(out_data), 32'(m_data));
            end
        end

`ifdef MUX41_STATS_EN
        rst_n = 1'b0;
        apply(4'b0000, 32'h0, 1'b1);
        clock();
        chk("cnt_reset", 32'(grant_cnt), 32'h0);
        rst_n = 1'b1;
        apply(4'b0010, 32'h0000AA00, 1'b1);
        for (int c = 0; c < 20; c++) begin
            clock();
            if (c == 9) chk("cnt_ten", 32'(grant_cnt), 32'h00A0);
        end
        chk("cnt_saturated", 32'(grant_cnt), 32'h00F0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
